conv_mac_engine: RTL and testbench
==================================

Name: conv_mac_engine

Overview:
Parametrised sequential multiply-accumulate engine for KxK convolution windows. It accepts one flattened window ("scope") and one flattened kernel per transaction over a valid/ready handshake. It accumulates one tap product per clock and returns the dot product over a valid/ready result channel. It sits between the window buffer and the output-pixel writer in the CAU, and is the generalised successor to the fixed 3x3 8-bit convolver.

Parameters:
DATA_W, 8, bit width of each scope/kernel element
K, 3, kernel dimension; taps N = K*K (K >= 1)
SIGNED, 0, 0 = unsigned elements and products; 1 = two's-complement elements and products
ACC_W, 2*DATA_W + $clog2(K*K), result width; derived, must not be overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  scope/kernel pair presented
in_ready  out  1  engine can accept a pair this cycle
scope  in  N*DATA_W  window; tap i at [i*DATA_W +: DATA_W]
kernel  in  N*DATA_W  weights; tap i at [i*DATA_W +: DATA_W]
out_valid  out  1  result holds a finished dot product
out_ready  in  1  consumer takes result this cycle
result  out  ACC_W  sum over i of scope[i]*kernel[i]
busy  out  1  high in ACCUM state

Behaviour:
- States: IDLE, ACCUM, DONE. Tap counter idx has width $clog2(N) (min 1). Captured scope/kernel are held in registers.
- Reset (rst=0, async): state=IDLE, idx=0, accumulator=0, result=0, out_valid=0, in_ready=1, busy=0. Any in-flight transaction is discarded and not reported.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only, never from in_valid.
- Accept = in_valid && in_ready. On accept edge: capture scope and kernel, set accumulator=0, idx=0, state=ACCUM.
- ACCUM: each edge adds product(tap idx) to the accumulator and increments idx. Tap 0 is processed first.
  - Product: DATA_W x DATA_W -> 2*DATA_W bits. SIGNED=1 sign-extends both operands and the product to ACC_W. SIGNED=0 zero-extends.
  - On the edge that adds tap N-1: final sum goes to result, out_valid=1, state=DONE, idx=0.
- Latency: accept on edge E0 -> out_valid rises after edge E0+N (N=9 at defaults). One product per cycle.
- DONE: result and out_valid are held stable while out_ready=0. Inputs are ignored because in_ready=0.
  - out_ready=1 and in_valid=0: out_valid clears next edge, state=IDLE.
  - out_ready=1 and in_valid=1: result is consumed and the new pair is accepted on the same edge. out_valid=0, state=ACCUM. This gives back-to-back throughput of one result per N+1 cycles.
- Scope/kernel may change freely after accept; only the captured copies are used.
- ACC_W is sized so the sum never overflows for any inputs. No saturation or wrap logic is permitted.
- result is unchanged outside the DONE-entry edge. It keeps the last value after consumption.
- K=1: N=1. The single product is added on the first ACCUM edge, which goes straight to DONE.

Test Plan:
- Reset: hold rst=0 mid-ACCUM (after 4 taps), release -> in_ready=1, out_valid=0, result=0, busy=0. Next transaction result is unaffected by the aborted one.
- Unsigned max (defaults): all scope and kernel bytes 0xFF, in_valid one cycle -> out_valid exactly 9 edges after accept, result=585225 (20'h8EE09).
- Signed (SIGNED=1): all bytes 0x80 -> result=147456 (20'h24000). Scope tap 0=0xFF, kernel tap 0=0x02, others 0 -> result=20'hFFFFE (-2).
- Identity kernel: kernel tap 4=1, others 0, scope taps 0..8 = 10..18 -> result=14. Scope changed right after accept -> result still 14.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0, second in_valid not accepted. Then out_ready=1 with in_valid=1 -> consume and accept on the same edge, second result valid 9 edges later.
- Parametric: DATA_W=4, K=2, SIGNED=0, all 0xF -> ACC_W=10, result=900 after 4 cycles. K=1, DATA_W=8: 3*5 -> result=15 one edge after accept.

Source files
------------

// File: rtl/conv_mac_engine_if.sv
// Handshake bundle between the window buffer, the MAC engine and the pixel writer.
// Input pair channel and result channel, each with its own valid/ready.
interface conv_mac_engine_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3
);
  localparam int N     = K * K;
  localparam int ACC_W = 2 * DATA_W + $clog2(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   scope;
  logic [N*DATA_W-1:0]   kernel;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      result;

  modport master (
    output in_valid, scope, kernel, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, scope, kernel, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/conv_mac_engine.sv
// Sequential KxK dot-product engine: one tap per clock, result valid N edges after accept.
// Result is held while out_ready is low; a new pair is only taken in IDLE or on the consuming edge.
module conv_mac_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_mac_engine_if.slave      bus,
  output logic                  busy
);
  localparam int N     = K * K;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx;
  logic [N*DATA_W-1:0]   scope_q, kernel_q;
  logic [ACC_W-1:0]      acc, acc_sum, result_q, prod_ext;
  logic [DATA_W-1:0]     tap_s, tap_k;
  logic [PW-1:0]         prod_u;
  logic signed [PW-1:0]  prod_s;
  logic                  accept, last_tap;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign busy          = (state == ACCUM);

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_tap = (idx == IDX_W'(N - 1));

  assign tap_s = scope_q[int'(idx)*DATA_W +: DATA_W];
  assign tap_k = kernel_q[int'(idx)*DATA_W +: DATA_W];

  // Operands are widened to the product width first so the multiply never truncates.
  always_comb begin
    prod_u = {{DATA_W{1'b0}}, tap_s} * {{DATA_W{1'b0}}, tap_k};
    prod_s = $signed({{DATA_W{tap_s[DATA_W-1]}}, tap_s}) *
             $signed({{DATA_W{tap_k[DATA_W-1]}}, tap_k});
    if (SIGNED != 0) prod_ext = ACC_W'(prod_s);
    else             prod_ext = ACC_W'(prod_u);
    acc_sum = acc + prod_ext;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.in_valid) state_d = ACCUM;
      ACCUM:   if (last_tap) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      acc      <= '0;
      result_q <= '0;
      scope_q  <= '0;
      kernel_q <= '0;
    end else if (accept) begin
      scope_q  <= bus.scope;
      kernel_q <= bus.kernel;
      acc      <= '0;
      idx      <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_sum;
      if (last_tap) begin
        result_q <= acc_sum;
        idx      <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench: four engine configurations, expected results queued at issue, checked by monitors.
module tb_conv_mac_engine;
  logic clk;
  logic rst0, rst_o;
  logic busy0, busy1, busy2, busy3;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];

  conv_mac_engine_if #(.DATA_W(8), .K(3)) bus0();
  conv_mac_engine_if #(.DATA_W(8), .K(3)) bus1();
  conv_mac_engine_if #(.DATA_W(4), .K(2)) bus2();
  conv_mac_engine_if #(.DATA_W(8), .K(1)) bus3();

  conv_mac_engine #(.DATA_W(8), .K(3), .SIGNED(0)) u0 (.clk(clk), .rst(rst0),  .bus(bus0), .busy(busy0));
  conv_mac_engine #(.DATA_W(8), .K(3), .SIGNED(1)) u1 (.clk(clk), .rst(rst_o), .bus(bus1), .busy(busy1));
  conv_mac_engine #(.DATA_W(4), .K(2), .SIGNED(0)) u2 (.clk(clk), .rst(rst_o), .bus(bus2), .busy(busy2));
  conv_mac_engine #(.DATA_W(8), .K(1), .SIGNED(0)) u3 (.clk(clk), .rst(rst_o), .bus(bus3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitors: pop and compare whenever a result is transferred.
  always @(negedge clk) begin
    if (rst0 && bus0.out_valid && bus0.out_ready) begin
      if (exp_q0.size() == 0) chk("u0 unexpected result", 32'(bus0.result), 32'hFFFF_FFFF);
      else                    chk("u0 result", 32'(bus0.result), exp_q0.pop_front());
    end
    if (rst_o && bus1.out_valid && bus1.out_ready) begin
      if (exp_q1.size() == 0) chk("u1 unexpected result", 32'(bus1.result), 32'hFFFF_FFFF);
      else                    chk("u1 result", 32'(bus1.result), exp_q1.pop_front());
    end
    if (rst_o && bus2.out_valid && bus2.out_ready) begin
      if (exp_q2.size() == 0) chk("u2 unexpected result", 32'(bus2.result), 32'hFFFF_FFFF);
      else                    chk("u2 result", 32'(bus2.result), exp_q2.pop_front());
    end
    if (rst_o && bus3.out_valid && bus3.out_ready) begin
      if (exp_q3.size() == 0) chk("u3 unexpected result", 32'(bus3.result), 32'hFFFF_FFFF);
      else                    chk("u3 result", 32'(bus3.result), exp_q3.pop_front());
    end
  end

  task automatic send0(input logic [71:0] s, input logic [71:0] k, input logic [31:0] e,
                       input bit push, output int t0);
    int n;
    if (push) exp_q0.push_back(e);
    bus0.scope = s; bus0.kernel = k; bus0.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    t0 = cyc;
    bus0.in_valid = 1'b0; bus0.scope = ~s; bus0.kernel = ~k;
  endtask

  task automatic wait_out0(input int t0, input int lat, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.out_valid && n < 50) begin @(negedge clk); n++; end
    chk(nm, 32'(cyc - t0), 32'(lat));
  endtask

  task automatic xfer0(input logic [71:0] s, input logic [71:0] k, input logic [31:0] e, input string nm);
    int t0;
    send0(s, k, e, 1'b1, t0);
    wait_out0(t0, 9, nm);
    @(posedge clk); #1;
  endtask

  task automatic xfer1(input logic [71:0] s, input logic [71:0] k, input logic [31:0] e, input string nm);
    int n, t0;
    exp_q1.push_back(e);
    bus1.scope = s; bus1.kernel = k; bus1.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    t0 = cyc; bus1.in_valid = 1'b0; bus1.scope = ~s; bus1.kernel = ~k;
    n = 0;
    @(negedge clk);
    while (!bus1.out_valid && n < 50) begin @(negedge clk); n++; end
    chk(nm, 32'(cyc - t0), 32'd9);
    @(posedge clk); #1;
  endtask

  task automatic xfer2(input logic [15:0] s, input logic [15:0] k, input logic [31:0] e, input string nm);
    int n, t0;
    exp_q2.push_back(e);
    bus2.scope = s; bus2.kernel = k; bus2.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus2.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    t0 = cyc; bus2.in_valid = 1'b0; bus2.scope = ~s; bus2.kernel = ~k;
    n = 0;
    @(negedge clk);
    while (!bus2.out_valid && n < 50) begin @(negedge clk); n++; end
    chk(nm, 32'(cyc - t0), 32'd4);
    @(posedge clk); #1;
  endtask

  task automatic xfer3(input logic [7:0] s, input logic [7:0] k, input logic [31:0] e, input string nm);
    int n, t0;
    exp_q3.push_back(e);
    bus3.scope = s; bus3.kernel = k; bus3.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus3.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    t0 = cyc; bus3.in_valid = 1'b0; bus3.scope = ~s; bus3.kernel = ~k;
    n = 0;
    @(negedge clk);
    while (!bus3.out_valid && n < 50) begin @(negedge clk); n++; end
    chk(nm, 32'(cyc - t0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [71:0] s, k, s_id, k_id, s_ramp, k_ramp, ones;
    int t0;

    ones = {9{8'hFF}};
    k_id = '0; k_id[4*8 +: 8] = 8'd1;
    for (int i = 0; i < 9; i++) begin
      s_id[i*8 +: 8]   = 8'(10 + i);
      s_ramp[i*8 +: 8] = 8'(i + 1);
      k_ramp[i*8 +: 8] = 8'(9 - i);
    end

    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.scope = '0; bus0.kernel = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.scope = '0; bus1.kernel = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.scope = '0; bus2.kernel = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b1; bus3.scope = '0; bus3.kernel = '0;
    rst0 = 1'b0; rst_o = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(bus0.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus0.out_valid), 32'd0);
    chk("reset result",    32'(bus0.result),    32'd0);
    chk("reset busy",      32'(busy0),          32'd0);
    rst0 = 1'b1; rst_o = 1'b1;
    @(posedge clk); #1;

    fork
      begin
        xfer0(ones, ones, 32'd585225, "u0 max latency");
        xfer0(s_ramp, k_ramp, 32'd165, "u0 ramp latency");
        xfer0(s_id, k_id, 32'd14, "u0 identity latency");

        // Abort a transaction four taps in; it must leave no trace.
        send0(ones, ones, 32'd0, 1'b0, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid-accum busy", 32'(busy0), 32'd1);
        rst0 = 1'b0;
        #1;
        chk("abort in_ready",  32'(bus0.in_ready),  32'd1);
        chk("abort out_valid", 32'(bus0.out_valid), 32'd0);
        chk("abort result",    32'(bus0.result),    32'd0);
        chk("abort busy",      32'(busy0),          32'd0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        xfer0(s_ramp, k_ramp, 32'd165, "u0 post-abort latency");

        // Backpressure: hold result, refuse a pending pair, then consume+accept on one edge.
        bus0.out_ready = 1'b0;
        send0(ones, ones, 32'd585225, 1'b1, t0);
        wait_out0(t0, 9, "bp first latency");
        exp_q0.push_back(32'd14);
        bus0.scope = s_id; bus0.kernel = k_id; bus0.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp hold out_valid", 32'(bus0.out_valid), 32'd1);
          chk("bp hold result",    32'(bus0.result),    32'h8EE09);
          chk("bp hold in_ready",  32'(bus0.in_ready),  32'd0);
          chk("bp hold busy",      32'(busy0),          32'd0);
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(bus0.in_ready), 32'd1);
        @(posedge clk); #1;
        t0 = cyc;
        bus0.in_valid = 1'b0; bus0.scope = ones;
        chk("bp accept busy",      32'(busy0),          32'd1);
        chk("bp accept out_valid", 32'(bus0.out_valid), 32'd0);
        wait_out0(t0, 9, "bp second latency");
        @(posedge clk); #1;
      end
      begin
        xfer1({9{8'h80}}, {9{8'h80}}, 32'h24000, "u1 min latency");
        s = '0; s[7:0] = 8'hFF; k = '0; k[7:0] = 8'h02;
        xfer1(s, k, 32'hFFFFE, "u1 neg latency");
        xfer1({9{8'h7F}}, {9{8'h80}}, 32'hDC480, "u1 mixed latency");
      end
      begin
        xfer2(16'hFFFF, 16'hFFFF, 32'd900, "u2 max latency");
        xfer2(16'h4321, 16'h1234, 32'd20, "u2 ramp latency");
      end
      begin
        xfer3(8'd3, 8'd5, 32'd15, "u3 small latency");
        xfer3(8'hFF, 8'hFF, 32'd65025, "u3 max latency");
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("u0 queue drained", 32'(exp_q0.size()), 32'd0);
    chk("u1 queue drained", 32'(exp_q1.size()), 32'd0);
    chk("u2 queue drained", 32'(exp_q2.size()), 32'd0);
    chk("u3 queue drained", 32'(exp_q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
